datapath_mc: RTL and testbench
==============================

// Module: datapath_mc
// PURPOSE
//  Multicycle successor of the single-cycle datapath: register file + RV-style ALU + handshaked data-memory port.
//  Controller issues one op per start/done transaction; the FSM sequences EXEC, optional MEM and WB.
//  Memory side tolerates variable latency (MemReq/MemAck) with a bounded timeout.
//  Sits between the controller and the data memory/cache.
// PARAMETERS
//  NBITS       8   datapath and register width (>=8)
//  NREGS       32  register count; x0 hardwired to zero
//  WIDTH_ALUF  4   ALUControl width
//  MEM_TIMEOUT 16  max MEM-state cycles without MemAck; 0 = wait forever
// PORTS
//  clock      in   1               rising-edge clock; single clock domain
//  reset      in   1               asynchronous, active-high
//  start      in   1               op valid; accepted only when ready=1
//  ready      out  1               FSM in IDLE
//  done       out  1               one-cycle pulse in WB
//  RS1,RS2,RD in   $clog2(NREGS)   register indices
//  IMM        in   NBITS           signed immediate
//  ALUControl in   WIDTH_ALUF      ALU opcode (datapath_pkg::alu_op_t)
//  ALUSrc     in   1               SrcB = IMM when 1, else reg[RS2]
//  MemRead    in   1               load: Result = ReadData
//  MemWrite   in   1               store reg[RS2]
//  RegWrite   in   1               write Result to RD in WB
//  link       in   1               Result = pclink (overrides all)
//  pclink     in   NBITS           PC value for link
//  PCReg      out  NBITS           latched SrcA for jump-register
//  Zero,Neg,Carry out 1 each       flags from SrcA-SrcB
//  MemErr     out  1               timeout; valid with done
//  MemReq     out  1               memory request
//  MemWe      out  1               1 = store
//  MemAck     in   1               memory completes request
//  Address    out  NBITS-2         ALUResult[NBITS-1:2] (word address)
//  WriteData  out  NBITS           store data
//  ReadData   in   NBITS           load data; sampled when MemAck=1
// BEHAVIOUR
//  Reset (async): all regs 0, state IDLE, ready=1, all other outputs 0.
//  IDLE: start&ready -> latch SrcA=reg[RS1], SrcB, store data, controls -> EXEC.
//  EXEC (1 cyc): ALUResult and flags registered. Next: MUL (MUL op, macro on) | MEM (MemRead|MemWrite) | WB.
//  MEM: MemReq=1; Address/MemWe/WriteData held stable until the MemAck cycle.
//   MemAck -> capture ReadData -> WB. Timeout: MEM_TIMEOUT cycles without MemAck -> MemErr=1 -> WB, no reg write.
//  WB: done=1; if RegWrite & RD!=0 & !MemErr write Result (link>MemRead>ALUResult) -> IDLE.
//  Latency: ALU op done 2 cyc after accept; memory op 3+wait cycles; ready low EXEC..WB.
//  MemRead & MemWrite both set: store only, Result = ALUResult.
//  ALU ops: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101;
//   undefined -> ADD. Shift amount = SrcB[$clog2(NBITS)-1:0]. Results truncated to NBITS.
//  Flags: Zero = A==B, Neg = signed A<B, Carry = carry-out of A+~B+1 (1 iff A>=B unsigned).
//   Updated in EXEC; held until next EXEC. PCReg updated at accept.
//  MemErr cleared on next accept. start outside IDLE ignored.
// CONFIGURATION
//  DATAPATH_MUL_EN defined: ALU op MUL=1010, iterative shift-add NBITS cycles in state MUL, low NBITS product.
//   Done NBITS+2 cycles after accept; flags still from SUB compare.
//  Undefined: 1010 decodes as ADD; no MUL state or logic.
// STRUCTURE
//  datapath_pkg: alu_op_t enum codes, state_t (IDLE, EXEC, MUL, MEM, WB).
//  Sub-module alu_mc: combinational ALU + flags; FSM, regfile, timeout counter and multiplier stay in top.
// TESTING (NBITS=8)
//  1. Load x1=5 (ALUSrc ADD IMM=5), x3=7; SUB x2,x1,x3 -> x2=0xFE, Zero=0 Neg=1 Carry=0, done 2 cyc after accept.
//  2. Store x1 at IMM=8: MemReq=1 MemWe=1 Address=2 WriteData=5 held 3 cyc with MemAck=0; ack -> done next cyc.
//  3. Load, MemAck never: MemErr=1 with done after 16 MEM cycles, RD unchanged, MemReq drops.
//  4. RD=0 RegWrite ADD IMM=9 -> x0 stays 0; link=1 pclink=0x40 RD=5 -> x5=0x40.
//  5. Assert reset while MemReq=1 -> MemReq=0 same cycle (async), regs 0, ready=1.
//  6. (DATAPATH_MUL_EN) 13*11 -> RD=0x8F, done 10 cyc after accept; undefined macro -> RD=24.

Source files
------------

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - ALU opcode and FSM state encodings shared by the multicycle datapath
package datapath_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_MUL  = 4'b1010,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_MEM,
    S_WB
  } state_t;

endpackage

// File: rtl/datapath_mc_if.sv
// rtl/datapath_mc_if.sv - controller and data-memory signal bundle for datapath_mc
interface datapath_mc_if #(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
);
  localparam int RW = $clog2(NREGS);

  logic                  start;
  logic                  ready;
  logic                  done;
  logic [RW-1:0]         RS1;
  logic [RW-1:0]         RS2;
  logic [RW-1:0]         RD;
  logic [NBITS-1:0]      IMM;
  logic [WIDTH_ALUF-1:0] ALUControl;
  logic                  ALUSrc;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  RegWrite;
  logic                  link;
  logic [NBITS-1:0]      pclink;
  logic [NBITS-1:0]      PCReg;
  logic                  Zero;
  logic                  Neg;
  logic                  Carry;
  logic                  MemErr;
  logic                  MemReq;
  logic                  MemWe;
  logic                  MemAck;
  logic [NBITS-3:0]      Address;
  logic [NBITS-1:0]      WriteData;
  logic [NBITS-1:0]      ReadData;

  // Datapath side
  modport slave (
    input  start, RS1, RS2, RD, IMM, ALUControl, ALUSrc, MemRead, MemWrite,
           RegWrite, link, pclink, MemAck, ReadData,
    output ready, done, PCReg, Zero, Neg, Carry, MemErr, MemReq, MemWe,
           Address, WriteData
  );

  // Controller / memory side
  modport master (
    output start, RS1, RS2, RD, IMM, ALUControl, ALUSrc, MemRead, MemWrite,
           RegWrite, link, pclink, MemAck, ReadData,
    input  ready, done, PCReg, Zero, Neg, Carry, MemErr, MemReq, MemWe,
           Address, WriteData
  );

endinterface

// File: rtl/datapath_mc_alu.sv
// rtl/datapath_mc_alu.sv - combinational RV-style ALU with compare flags (module alu_mc)
module alu_mc
  import datapath_pkg::*;
#(
  parameter int NBITS      = 8,
  parameter int WIDTH_ALUF = 4
) (
  input  logic [NBITS-1:0]      a,
  input  logic [NBITS-1:0]      b,
  input  logic [WIDTH_ALUF-1:0] op,
  output logic [NBITS-1:0]      result,
  output logic                  zero,
  output logic                  neg,
  output logic                  carry
);
  localparam int SHW = $clog2(NBITS);

  logic [SHW-1:0]   shamt;
  logic [NBITS-1:0] diff;

  assign shamt = b[SHW-1:0];

  // Flags always come from A-B so that branches work regardless of the opcode
  assign {carry, diff} = {1'b0, a} + {1'b0, ~b} + {{NBITS{1'b0}}, 1'b1};
  assign zero = (a == b);
  assign neg  = ($signed(a) < $signed(b));

  // Opcode decode; anything not listed (including MUL, handled by the top) falls back to ADD
  always_comb begin
    result = a + b;
    case (op)
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(NBITS-1){1'b0}}, neg};
      ALU_SLTU: result = {{(NBITS-1){1'b0}}, ~carry};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_SUB:  result = diff;
      ALU_SRA:  result = NBITS'($signed(a) >>> shamt);
      default:  result = a + b;
    endcase
  end

endmodule

// File: rtl/datapath_mc.sv
// rtl/datapath_mc.sv - multicycle datapath top: FSM, register file, memory timeout; DATAPATH_MUL_EN adds shift-add MUL
module datapath_mc
  import datapath_pkg::*;
#(
  parameter int NBITS       = 8,
  parameter int NREGS       = 32,
  parameter int WIDTH_ALUF  = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input logic           clock,
  input logic           reset,
  datapath_mc_if.slave  bus
);
  localparam int RW = $clog2(NREGS);
  localparam int TW = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [TW-1:0] TMO_ONE = 1;
`ifdef DATAPATH_MUL_EN
  localparam int CW = $clog2(NBITS) + 1;
  localparam logic [CW-1:0] MUL_ONE  = 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(NBITS - 1);
`endif

  state_t                state_q, state_d;
  logic [NBITS-1:0]      regs_q [NREGS];
  logic [NBITS-1:0]      src_a_q, src_a_d, src_b_q, src_b_d;
  logic [NBITS-1:0]      st_data_q, st_data_d;
  logic [RW-1:0]         rd_q, rd_d;
  logic [WIDTH_ALUF-1:0] op_q, op_d;
  logic                  mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic                  reg_write_q, reg_write_d, link_q, link_d;
  logic [NBITS-1:0]      pclink_q, pclink_d;
  logic [NBITS-1:0]      alu_res_q, alu_res_d, rdata_q, rdata_d, pc_reg_q, pc_reg_d;
  logic                  zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
  logic                  mem_err_q, mem_err_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                  ready_q, ready_d, done_q, done_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
`ifdef DATAPATH_MUL_EN
  logic [CW-1:0]         mul_cnt_q, mul_cnt_d;
`endif

  logic [NBITS-1:0]      alu_y;
  logic                  alu_zero, alu_neg, alu_carry;
  logic                  wr_en;
  logic [NBITS-1:0]      wr_data;

  alu_mc #(.NBITS(NBITS), .WIDTH_ALUF(WIDTH_ALUF)) u_alu (
    .a      (src_a_q),
    .b      (src_b_q),
    .op     (op_q),
    .result (alu_y),
    .zero   (alu_zero),
    .neg    (alu_neg),
    .carry  (alu_carry)
  );

  // Next-state and next-output computation for the EXEC/MUL/MEM/WB sequence
  always_comb begin
    state_d     = state_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    st_data_d   = st_data_q;
    rd_d        = rd_q;
    op_d        = op_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    reg_write_d = reg_write_q;
    link_d      = link_q;
    pclink_d    = pclink_q;
    alu_res_d   = alu_res_q;
    rdata_d     = rdata_q;
    pc_reg_d    = pc_reg_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    mem_err_d   = mem_err_q;
    tmo_cnt_d   = tmo_cnt_q;
`ifdef DATAPATH_MUL_EN
    mul_cnt_d   = mul_cnt_q;
`endif
    wr_en       = 1'b0;
    // A store with MemRead also set keeps the ALU result
    if (link_q)
      wr_data = pclink_q;
    else if (mem_read_q && !mem_write_q)
      wr_data = rdata_q;
    else
      wr_data = alu_res_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          src_a_d     = regs_q[bus.RS1];
          src_b_d     = bus.ALUSrc ? bus.IMM : regs_q[bus.RS2];
          st_data_d   = regs_q[bus.RS2];
          pc_reg_d    = regs_q[bus.RS1];
          rd_d        = bus.RD;
          op_d        = bus.ALUControl;
          mem_read_d  = bus.MemRead;
          mem_write_d = bus.MemWrite;
          reg_write_d = bus.RegWrite;
          link_d      = bus.link;
          pclink_d    = bus.pclink;
          mem_err_d   = 1'b0;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_res_d = alu_y;
        zero_d    = alu_zero;
        neg_d     = alu_neg;
        carry_d   = alu_carry;
        tmo_cnt_d = '0;
        if (mem_read_q || mem_write_q)
          state_d = S_MEM;
        else
          state_d = S_WB;
`ifdef DATAPATH_MUL_EN
        if (op_q == ALU_MUL) begin
          alu_res_d = '0;
          mul_cnt_d = '0;
          state_d   = S_MUL;
        end
`endif
      end
`ifdef DATAPATH_MUL_EN
      S_MUL: begin
        // One partial product per cycle; operands are consumed in place
        if (src_b_q[0])
          alu_res_d = alu_res_q + src_a_q;
        src_a_d   = src_a_q << 1;
        src_b_d   = src_b_q >> 1;
        mul_cnt_d = mul_cnt_q + MUL_ONE;
        if (mul_cnt_q == MUL_LAST)
          state_d = S_WB;
      end
`endif
      S_MEM: begin
        if (bus.MemAck) begin
          rdata_d = bus.ReadData;
          state_d = S_WB;
        end else if ((MEM_TIMEOUT != 0) && (32'(tmo_cnt_q) == MEM_TIMEOUT - 1)) begin
          mem_err_d = 1'b1;
          state_d   = S_WB;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end
      end
      S_WB: begin
        wr_en   = reg_write_q && (rd_q != '0) && !mem_err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d   = (state_d == S_IDLE);
    done_d    = (state_d == S_WB);
    mem_req_d = (state_d == S_MEM);
    mem_we_d  = (state_d == S_MEM) && mem_write_d;
  end

  // State, latched operands and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_a_q     <= '0;
      src_b_q     <= '0;
      st_data_q   <= '0;
      rd_q        <= '0;
      op_q        <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      link_q      <= 1'b0;
      pclink_q    <= '0;
      alu_res_q   <= '0;
      rdata_q     <= '0;
      pc_reg_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      mem_err_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
`ifdef DATAPATH_MUL_EN
      mul_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      st_data_q   <= st_data_d;
      rd_q        <= rd_d;
      op_q        <= op_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      link_q      <= link_d;
      pclink_q    <= pclink_d;
      alu_res_q   <= alu_res_d;
      rdata_q     <= rdata_d;
      pc_reg_q    <= pc_reg_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      mem_err_q   <= mem_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
`ifdef DATAPATH_MUL_EN
      mul_cnt_q   <= mul_cnt_d;
`endif
    end
  end

  // Register file; x0 is never written so it reads as zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rd_q] <= wr_data;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.PCReg     = pc_reg_q;
  assign bus.Zero      = zero_q;
  assign bus.Neg       = neg_q;
  assign bus.Carry     = carry_q;
  assign bus.MemErr    = mem_err_q;
  assign bus.MemReq    = mem_req_q;
  assign bus.MemWe     = mem_we_q;
  assign bus.Address   = alu_res_q[NBITS-1:2];
  assign bus.WriteData = st_data_q;

endmodule

// File: tb/tb_datapath_mc.sv
// tb/tb_datapath_mc.sv - randomized self-checking bench for datapath_mc against a behavioural model
module tb_datapath_mc;

  logic clock;
  logic reset;

  datapath_mc_if bus ();

  datapath_mc dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk;
  int n_pass;
  logic [7:0] mregs [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] m_alu(input int op, input logic [7:0] a, input logic [7:0] b);
    int sh;
    int sa;
    int sb;
    sh = int'(b) % 8;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      1:  return 8'(int'(a) * (1 << sh));
      2:  return (sa < sb) ? 8'd1 : 8'd0;
      3:  return (int'(a) < int'(b)) ? 8'd1 : 8'd0;
      4:  return a ^ b;
      5:  return 8'(int'(a) / (1 << sh));
      6:  return a | b;
      7:  return a & b;
      8:  return 8'(int'(a) - int'(b));
      13: return 8'(sa >>> sh);
`ifdef DATAPATH_MUL_EN
      10: return 8'(int'(a) * int'(b));
`endif
      default: return 8'(int'(a) + int'(b));
    endcase
  endfunction

  task automatic idle_inputs();
    bus.start = 0; bus.RS1 = 0; bus.RS2 = 0; bus.RD = 0; bus.IMM = 0;
    bus.ALUControl = 0; bus.ALUSrc = 0; bus.MemRead = 0; bus.MemWrite = 0;
    bus.RegWrite = 0; bus.link = 0; bus.pclink = 0; bus.MemAck = 0; bus.ReadData = 0;
  endtask

  // Issue one op at a negedge and follow it to completion, returning at a negedge
  task automatic run_op(input int op, input int rs1, input int rs2, input int rd, input int imm,
                        input bit alusrc, input bit mr, input bit mw, input bit rw, input bit lnk,
                        input int plink, input int ack_wait, input bit never, input string tag);
    logic [7:0] a, b, res, rdat, wval;
    int exp_lat, cyc, memcyc, sa, sb;
    bit mem, err, is_mul, seen_done;
    a = mregs[rs1];
    b = alusrc ? 8'(imm) : mregs[rs2];
    res = m_alu(op, a, b);
    sa = $signed(a);
    sb = $signed(b);
    is_mul = 0;
`ifdef DATAPATH_MUL_EN
    is_mul = (op == 10);
`endif
    mem = (mr || mw) && !is_mul;
    err = mem && never;
    rdat = 8'($urandom);
    exp_lat = is_mul ? 10 : !mem ? 2 : never ? 18 : 3 + ack_wait;

    bus.start = 1; bus.RS1 = 5'(rs1); bus.RS2 = 5'(rs2); bus.RD = 5'(rd); bus.IMM = 8'(imm);
    bus.ALUControl = 4'(op); bus.ALUSrc = alusrc; bus.MemRead = mr; bus.MemWrite = mw;
    bus.RegWrite = rw; bus.link = lnk; bus.pclink = 8'(plink);
    @(posedge clock);
    cyc = 0;
    memcyc = 0;
    seen_done = 0;
    while (!seen_done && cyc < 64) begin
      @(negedge clock);
      cyc++;
      if (bus.done) begin
        seen_done = 1;
        bus.start = 0;
        bus.MemAck = 0;
      end else begin
        // Garbage start while busy must be ignored
        bus.start = 1; bus.RS1 = 5'($urandom); bus.RS2 = 5'($urandom); bus.RD = 5'($urandom);
        bus.IMM = 8'($urandom); bus.RegWrite = 1;
        bus.MemAck = 0;
        if (bus.MemReq) begin
          chk({tag, ":memwe"}, 32'(bus.MemWe), 32'(mw));
          chk({tag, ":addr"}, 32'(bus.Address), 32'(res[7:2]));
          chk({tag, ":wdata"}, 32'(bus.WriteData), 32'(mregs[rs2]));
          if (!never && memcyc == ack_wait) begin
            bus.MemAck = 1;
            bus.ReadData = rdat;
          end
          memcyc++;
        end
      end
    end
    chk({tag, ":done_seen"}, 32'(seen_done), 32'd1);
    chk({tag, ":latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, ":memerr"}, 32'(bus.MemErr), 32'(err));
    chk({tag, ":zero"}, 32'(bus.Zero), 32'(a == b));
    chk({tag, ":neg"}, 32'(bus.Neg), 32'(sa < sb));
    chk({tag, ":carry"}, 32'(bus.Carry), 32'(int'(a) >= int'(b)));
    chk({tag, ":pcreg"}, 32'(bus.PCReg), 32'(a));
    if (rw && rd != 0 && !err) begin
      if (lnk) wval = 8'(plink);
      else if (mem && mr && !mw) wval = rdat;
      else wval = res;
      mregs[rd] = wval;
    end
    @(negedge clock);
    chk({tag, ":post_ready"}, 32'(bus.ready), 32'd1);
    chk({tag, ":post_done"}, 32'(bus.done), 32'd0);
    chk({tag, ":post_memreq"}, 32'(bus.MemReq), 32'd0);
  endtask

  // Read a register through PCReg with a harmless non-writing op
  task automatic read_reg(input int r, input string tag);
    run_op(0, r, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    int ops[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 13, 10, 9, 15};
    int cnt;
    n_chk = 0;
    n_pass = 0;
    for (int i = 0; i < 32; i++) mregs[i] = 8'd0;
    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clock);
    chk("rst:ready", 32'(bus.ready), 32'd1);
    chk("rst:done", 32'(bus.done), 32'd0);
    chk("rst:memreq", 32'(bus.MemReq), 32'd0);
    chk("rst:pcreg", 32'(bus.PCReg), 32'd0);
    chk("rst:addr", 32'(bus.Address), 32'd0);
    chk("rst:memerr", 32'(bus.MemErr), 32'd0);
    reset = 0;
    @(negedge clock);

    // Basic ALU ops and flags
    run_op(0, 0, 0, 1, 5, 1, 0, 0, 1, 0, 0, 0, 0, "ld_x1");
    run_op(0, 0, 0, 3, 7, 1, 0, 0, 1, 0, 0, 0, 0, "ld_x3");
    run_op(8, 1, 3, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, "sub");
    read_reg(2, "rd_x2");
    chk("sub_val", 32'(bus.PCReg), 32'hFE);
    // Store with a 3-cycle memory wait
    run_op(0, 0, 1, 0, 8, 1, 0, 1, 0, 0, 0, 3, 0, "store");
    // Load that never completes
    run_op(0, 0, 0, 4, 4, 1, 1, 0, 1, 0, 0, 0, 1, "tmo");
    read_reg(4, "rd_x4");
    // x0 stays zero; link writes pclink
    run_op(0, 0, 0, 0, 9, 1, 0, 0, 1, 0, 0, 0, 0, "x0wr");
    read_reg(0, "rd_x0");
    run_op(0, 0, 0, 5, 0, 1, 0, 0, 1, 1, 8'h40, 0, 0, "link");
    read_reg(5, "rd_x5");
    chk("link_val", 32'(bus.PCReg), 32'h40);
    // Multiply encoding
    run_op(0, 0, 0, 6, 13, 1, 0, 0, 1, 0, 0, 0, 0, "ld_x6");
    run_op(0, 0, 0, 7, 11, 1, 0, 0, 1, 0, 0, 0, 0, "ld_x7");
    run_op(10, 6, 7, 8, 0, 0, 0, 0, 1, 0, 0, 0, 0, "mul");
    read_reg(8, "rd_x8");

    // Randomized ops; registers confined to x0..x7 for reuse
    for (int n = 0; n < 60; n++) begin
      int op, rs1, rs2, rd, imm, kind, wt;
      bit mr, mw, nev, lnk;
      op = ops[$urandom_range(0, 12)];
      rs1 = $urandom_range(0, 7);
      rs2 = $urandom_range(0, 7);
      rd = $urandom_range(0, 7);
      imm = $urandom_range(0, 255);
      kind = $urandom_range(0, 3);
      mr = 0; mw = 0; nev = 0;
      if (kind == 0 && op != 10) begin
        mr = 1'($urandom);
        mw = 1'($urandom);
        if (!mr && !mw) mr = 1;
        nev = ($urandom_range(0, 7) == 0);
      end
      lnk = ($urandom_range(0, 9) == 0);
      wt = $urandom_range(0, 4);
      run_op(op, rs1, rs2, rd, imm, 1'($urandom), mr, mw, 1'($urandom), lnk,
             $urandom_range(0, 255), wt, nev, "rnd");
      read_reg(rd, "rnd_rb");
    end

    // Async reset in the middle of a memory request
    bus.start = 1; bus.RS1 = 1; bus.RD = 9; bus.IMM = 4; bus.ALUSrc = 1;
    bus.ALUControl = 0; bus.MemRead = 1; bus.MemWrite = 0; bus.RegWrite = 1; bus.link = 0;
    @(posedge clock);
    cnt = 0;
    do begin
      @(negedge clock);
      bus.start = 0;
      cnt++;
    end while (!bus.MemReq && cnt < 8);
    chk("arst:memreq_pre", 32'(bus.MemReq), 32'd1);
    #2 reset = 1;
    #1;
    chk("arst:memreq", 32'(bus.MemReq), 32'd0);
    chk("arst:ready", 32'(bus.ready), 32'd1);
    chk("arst:pcreg", 32'(bus.PCReg), 32'd0);
    for (int i = 0; i < 32; i++) mregs[i] = 8'd0;
    @(negedge clock);
    idle_inputs();
    reset = 0;
    @(negedge clock);
    read_reg(1, "arst_x1");
    read_reg(5, "arst_x5");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
